// File: rtl/adder_result_stage.sv
// adder_result_stage
//   Registered 2-entry valid/ready buffer placed after the adder. It captures
//   {sum, overflow, zero, sub} so that a downstream stall never reaches back
//   combinationally to the operand source. It also tracks ALU status: a sticky
//   overflow bit and a saturating count of accepted overflow results.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake (in_ready depends on registered state and rst only)
//   in_sum/_overflow/_zero/_sub    adder result payload
//   out_valid/out_ready   downstream handshake, head entry presented on out_*
//   clear_status          zeroes sticky_overflow and ovf_count (an accepted overflow event wins)
//   sticky_overflow       set by any accepted overflow result
//   ovf_count             saturating count of accepted overflow results
module adder_result_stage #(
    parameter int WIDTH         = 32,
    parameter int OVF_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_sum,
    input  logic                     in_overflow,
    input  logic                     in_zero,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_overflow,
    output logic                     out_zero,
    output logic                     out_sub,
    input  logic                     clear_status,
    output logic                     sticky_overflow,
    output logic [OVF_CNT_WIDTH-1:0] ovf_count
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             ovf;
        logic             zero;
        logic             sub;
    } entry_t;

    entry_t [1:0]             mem_q,    mem_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               count_q,  count_d;
    logic                     sticky_q, sticky_d;
    logic [OVF_CNT_WIDTH-1:0] cnt_q,    cnt_d;

    logic   push, pop;
    entry_t in_entry, head;

    // Ready comes purely from occupancy so out_ready never feeds in_ready.
    assign in_ready = !rst && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign in_entry = '{sum: in_sum, ovf: in_overflow, zero: in_zero, sub: in_sub};
    assign head     = mem_q[rd_ptr_q];

    assign out_sum         = head.sum;
    assign out_overflow    = head.ovf;
    assign out_zero        = head.zero;
    assign out_sub         = head.sub;
    assign sticky_overflow = sticky_q;
    assign ovf_count       = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
    end

    // An accepted overflow takes priority over clear: the cleared count
    // restarts at 1 for that event.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (push && in_overflow) begin
            sticky_d = 1'b1;
            if (clear_status)
                cnt_d = {{(OVF_CNT_WIDTH-1){1'b0}}, 1'b1};
            else if (cnt_q != {OVF_CNT_WIDTH{1'b1}})
                cnt_d = cnt_q + 1'b1;
        end else if (clear_status) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_adder_result_stage.sv
module tb_adder_result_stage;

    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_sum = '0;
    logic        in_overflow = 1'b0, in_zero = 1'b0, in_sub = 1'b0;
    logic        out_ready = 1'b0;
    logic        clear_status = 1'b0;

    logic        in_ready, out_valid, out_overflow, out_zero, out_sub, sticky_overflow;
    logic [31:0] out_sum;
    logic [7:0]  ovf_count;

    logic        d2_in_ready, d2_out_valid, d2_out_overflow, d2_out_zero, d2_out_sub, d2_sticky;
    logic [31:0] d2_out_sum;
    logic [1:0]  d2_cnt;

    int total = 0;
    int bad   = 0;

    logic [34:0] exp_q[$];

    always #5 clk = ~clk;

    adder_result_stage #(.WIDTH(32), .OVF_CNT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_overflow(in_overflow), .in_zero(in_zero), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_overflow(out_overflow), .out_zero(out_zero), .out_sub(out_sub),
        .clear_status(clear_status), .sticky_overflow(sticky_overflow), .ovf_count(ovf_count)
    );

    // Narrow-counter instance for the saturation corner.
    adder_result_stage #(.WIDTH(32), .OVF_CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(d2_in_ready),
        .in_sum(in_sum), .in_overflow(in_overflow), .in_zero(in_zero), .in_sub(in_sub),
        .out_valid(d2_out_valid), .out_ready(out_ready),
        .out_sum(d2_out_sum), .out_overflow(d2_out_overflow), .out_zero(d2_out_zero), .out_sub(d2_out_sub),
        .clear_status(clear_status), .sticky_overflow(d2_sticky), .ovf_count(d2_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: handshakes are sampled mid-cycle, ahead of the edge that performs them.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got=%0h want=none (t=%0t)", out_sum, $time);
                end else begin
                    chk("sb_payload", {29'd0, out_sum, out_overflow, out_zero, out_sub}, {29'd0, exp_q.pop_front()});
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back({in_sum, in_overflow, in_zero, in_sub});
        end
    end

    task automatic step(input bit r, input bit v, input logic [31:0] s, input bit o, input bit rd, input bit c);
        @(posedge clk);
        #1;
        rst          = r;
        in_valid     = v;
        in_sum       = s;
        in_overflow  = o;
        in_zero      = s[4];
        in_sub       = s[0];
        out_ready    = rd;
        clear_status = c;
        @(negedge clk);
    endtask

    typedef struct {
        bit          r, v;
        logic [31:0] s;
        bit          o, rd, c;
        bit          e_irdy, e_ovld, chk_sum;
        logic [31:0] e_sum;
        bit          e_sticky;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[21];

    initial begin
        // reset, two cycles
        vecs[0]  = '{T,F,32'h0,F,F,F,          F,F,T,32'h0,F,8'd0};
        vecs[1]  = '{T,F,32'h0,F,F,F,          F,F,T,32'h0,F,8'd0};
        // streaming 1,2,3 with out_ready high
        vecs[2]  = '{F,T,32'h1,F,T,F,          T,F,F,32'h0,F,8'd0};
        vecs[3]  = '{F,T,32'h2,F,T,F,          T,T,T,32'h1,F,8'd0};
        vecs[4]  = '{F,T,32'h3,F,T,F,          T,T,T,32'h2,F,8'd0};
        vecs[5]  = '{F,F,32'h0,F,T,F,          T,T,T,32'h3,F,8'd0};
        vecs[6]  = '{F,F,32'h0,F,T,F,          T,F,F,32'h0,F,8'd0};
        // backpressure: fill, hold, then drain
        vecs[7]  = '{F,T,32'hAAAA0000,F,F,F,   T,F,F,32'h0,F,8'd0};
        vecs[8]  = '{F,T,32'h5555FFFF,F,F,F,   T,T,T,32'hAAAA0000,F,8'd0};
        vecs[9]  = '{F,T,32'h0000BEEF,F,F,F,   F,T,T,32'hAAAA0000,F,8'd0};
        vecs[10] = '{F,T,32'h0000BEEF,F,F,F,   F,T,T,32'hAAAA0000,F,8'd0};
        vecs[11] = '{F,T,32'h0000BEEF,F,T,F,   F,T,T,32'hAAAA0000,F,8'd0};
        vecs[12] = '{F,T,32'h0000BEEF,F,T,F,   T,T,T,32'h5555FFFF,F,8'd0};
        vecs[13] = '{F,F,32'h0,F,T,F,          T,T,T,32'h0000BEEF,F,8'd0};
        vecs[14] = '{F,F,32'h0,F,T,F,          T,F,F,32'h0,F,8'd0};
        // status: three overflow results then one clean
        vecs[15] = '{F,T,32'h10,T,T,F,         T,F,F,32'h0,F,8'd0};
        vecs[16] = '{F,T,32'h11,T,T,F,         T,T,T,32'h10,T,8'd1};
        vecs[17] = '{F,T,32'h12,T,T,F,         T,T,T,32'h11,T,8'd2};
        vecs[18] = '{F,T,32'h13,F,T,F,         T,T,T,32'h12,T,8'd3};
        vecs[19] = '{F,F,32'h0,F,T,F,          T,T,T,32'h13,T,8'd3};
        vecs[20] = '{F,F,32'h0,F,T,F,          T,F,F,32'h0,T,8'd3};

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].o, vecs[i].rd, vecs[i].c);
            chk($sformatf("v%0d_in_ready", i),  {63'd0, in_ready},        {63'd0, vecs[i].e_irdy});
            chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid},       {63'd0, vecs[i].e_ovld});
            chk($sformatf("v%0d_sticky", i),    {63'd0, sticky_overflow}, {63'd0, vecs[i].e_sticky});
            chk($sformatf("v%0d_ovf_count", i), {56'd0, ovf_count},       {56'd0, vecs[i].e_cnt});
            if (vecs[i].chk_sum)
                chk($sformatf("v%0d_out_sum", i), {32'd0, out_sum}, {32'd0, vecs[i].e_sum});
        end

        // clear coinciding with an accepted overflow: the event wins
        step(F, T, 32'h20, T, T, T);
        step(F, F, 32'h0,  F, T, F);
        chk("clr_evt_count",  {56'd0, ovf_count},       64'd1);
        chk("clr_evt_sticky", {63'd0, sticky_overflow}, 64'd1);
        chk("clr_evt_count2", {62'd0, d2_cnt},          64'd1);
        // clear alone
        step(F, F, 32'h0, F, T, T);
        step(F, F, 32'h0, F, T, F);
        chk("clr_count",  {56'd0, ovf_count},       64'd0);
        chk("clr_sticky", {63'd0, sticky_overflow}, 64'd0);

        // saturation on the 2-bit counter
        for (int i = 0; i < 5; i++)
            step(F, T, 32'h30 + i, T, T, F);
        step(F, F, 32'h0, F, T, F);
        chk("sat_count2", {62'd0, d2_cnt},    64'd3);
        chk("sat_count8", {56'd0, ovf_count}, 64'd5);
        step(F, F, 32'h0, F, T, F);

        // reset mid-operation with a full buffer
        step(F, T, 32'hA1, F, F, F);
        step(F, T, 32'hB2, F, F, F);
        step(F, F, 32'h0,  F, F, F);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        step(T, F, 32'h0, F, F, F);
        chk("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
        step(F, T, 32'h12345678, F, T, F);
        chk("rst_out_valid", {63'd0, out_valid},       64'd0);
        chk("rst_sticky",    {63'd0, sticky_overflow}, 64'd0);
        chk("rst_count",     {56'd0, ovf_count},       64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},        64'd1);
        step(F, F, 32'h0, F, T, F);
        chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("post_rst_sum",   {32'd0, out_sum},   64'h12345678);
        step(F, F, 32'h0, F, T, F);
        chk("post_rst_alone", {63'd0, out_valid}, 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_result_stage.md
# adder_result_stage

Registered output stage placed directly downstream of the `adder`. It captures each adder result (sum plus overflow/zero flags) into a 2-entry valid/ready buffer, so that downstream stalls never need a combinational path back to the operand source. It also keeps ALU status: a sticky overflow bit and a saturating count of overflow events.

## Interface

Parameters:
- WIDTH, 32, width of the sum; must match the upstream `adder` WIDTH.
- OVF_CNT_WIDTH, 8, width of the overflow event counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream result is valid this cycle.
- in_ready  out  1  stage can accept a result this cycle.
- in_sum  in  WIDTH  adder sum `o`.
- in_overflow  in  1  adder `overflow_flag`.
- in_zero  in  1  adder `zero_flag`.
- in_sub  in  1  `invert_i_2` value used for this result; carried as tag only.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream accepts the head entry.
- out_sum  out  WIDTH  head entry sum.
- out_overflow  out  1  head entry overflow flag.
- out_zero  out  1  head entry zero flag.
- out_sub  out  1  head entry subtract tag.
- clear_status  in  1  clears sticky_overflow and ovf_count.
- sticky_overflow  out  1  set once any accepted result had overflow.
- ovf_count  out  OVF_CNT_WIDTH  number of accepted results with overflow; saturating.

## Operation

**Buffer**
- 2-entry FIFO holding payload {sum, overflow, zero, sub}.
- Write pointer (wr_ptr) and read pointer (rd_ptr) are 1 bit each; occupancy count is 0..2.
- Push: in_valid & in_ready. The entry is written at wr_ptr, then wr_ptr toggles.
- Pop: out_valid & out_ready. rd_ptr toggles.
- in_ready = !rst & (count != 2). It depends only on registered state, never on out_ready.
- out_valid = (count != 0). The out_* payload is always the entry at rd_ptr.
- There is no bypass path: an empty stage never presents the input on the output in the same cycle.
- Simultaneous push and pop:
  - count 1: count stays 1; the new entry becomes head on the next cycle.
  - count 2: cannot occur, because in_ready = 0.
  - count 0: cannot occur, because out_valid = 0.
- While out_valid = 1 and out_ready = 0, all out_* signals are held stable.
- Inputs are ignored when in_ready = 0, even if in_valid = 1. The upstream source holds them.

**Status**
- An accepted result with in_overflow = 1 sets sticky_overflow and increments ovf_count.
- Status is updated on acceptance, not on pop.
- ovf_count saturates at 2^OVF_CNT_WIDTH − 1 and never wraps.
- clear_status = 1 zeroes both status outputs on the next edge.
- If clear_status coincides with an accepted overflow result, the event wins: sticky_overflow = 1 and ovf_count = 1.
- clear_status has no effect on buffer contents.

**Reset**
- At the rst edge: count = 0, both pointers = 0, storage payload = 0, sticky_overflow = 0, ovf_count = 0.
- Reset values of outputs: out_valid = 0, out_* payload = 0, sticky_overflow = 0, ovf_count = 0.
- in_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
- Reset asserted mid-operation discards all buffered entries. Pending handshakes in that cycle are not performed.

## Timing

- Latency: a result accepted at edge N is presented with out_valid = 1 in the cycle after edge N. Minimum latency is 1 cycle.
- Throughput: 1 result per cycle when out_ready is held high.
- The second entry absorbs one cycle of downstream stall without a bubble.
- in_ready falls in the cycle after the buffer fills, and rises in the cycle after the first pop from full.
- Status outputs are registered. They reflect an accepted overflow from the cycle after acceptance.
- No combinational path exists from any in_* input or out_ready to any output, except rst → in_ready.

## Test plan

1. **Reset values.** Drive rst = 1 for 2 cycles, then deassert.
   - During reset: out_valid = 0, in_ready = 0, ovf_count = 0, sticky_overflow = 0.
   - First cycle after reset: in_ready = 1.
2. **Streaming.** Hold out_ready = 1 and push sums 0x00000001, 0x00000002, 0x00000003 on consecutive cycles.
   - Outputs appear in order, each 1 cycle after acceptance.
   - in_ready stays 1 throughout; no bubbles.
3. **Backpressure.** Hold out_ready = 0 and push 0xAAAA0000, then 0x5555FFFF.
   - in_ready = 0 after the second accept; a third in_valid is not consumed.
   - out_sum is held at 0xAAAA0000.
   - Raise out_ready: 0xAAAA0000, 0x5555FFFF and the third value drain in order.
4. **Status counter.** Push 3 results with in_overflow = 1 and 1 with in_overflow = 0.
   - Result: ovf_count = 3, sticky_overflow = 1.
   - With OVF_CNT_WIDTH = 2, push 5 overflow results: ovf_count holds at 3.
5. **Clear versus event.** Assert clear_status in the same cycle as an accepted overflow result: next cycle ovf_count = 1 and sticky_overflow = 1. Assert clear_status alone: both go to 0.
6. **Reset mid-operation.** Fill the buffer (2 entries) with out_ready = 0, then pulse rst for 1 cycle.
   - Next cycle: out_valid = 0 and status is cleared.
   - A subsequent push of 0x12345678 emerges alone.
